serial_add_ctrl: RTL

- Sequencer that performs an N-bit add with carry-in by time-sharing a single half-adder cell, LSB first.
- Uses two half-adder passes per bit: pass 1 computes a_i^b_i and a_i&b_i; pass 2 computes x^c and x&c.
- Sits between a requester issuing start/operands and the shared half-adder, as the area-minimal adder for slow control paths.
- Handshake is start/busy/done; results are registered and held.

---
 rtl/serial_add_ctrl_pkg.sv | 19 +
 rtl/serial_add_ctrl_ha_str.sv | 13 +
 rtl/serial_add_ctrl.sv | 127 ++++++++++++
 3 files changed

// File: rtl/serial_add_ctrl_pkg.sv
// Shared definitions for the serial adder sequencer: FSM encoding, default width
// and the bit-counter width helper.
package serial_add_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        P1   = 2'd1,
        P2   = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam int DEFAULT_WIDTH = 8;

    // A 1-bit adder still needs a 1-bit counter register.
    function automatic int cnt_w(input int w);
        return (w <= 1) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/serial_add_ctrl_ha_str.sv
// Gate-level half adder; the single arithmetic cell shared by every pass of the
// serial adder.
module serial_add_ctrl_ha_str (
    input  logic a_i,
    input  logic b_i,
    output logic sum_o,
    output logic carry_o
);

    xor g_sum   (sum_o,   a_i, b_i);
    and g_carry (carry_o, a_i, b_i);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial N-bit adder with carry-in: each bit takes two passes through one
// shared half adder (P1: a^b / a&b, P2: x^c / x&c), LSB first.
module serial_add_ctrl
    import serial_add_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = cnt_w(WIDTH);

    state_e           state_q;
    logic [WIDTH-1:0] a_sh_q, b_sh_q, s_sh_q, s_sh_d;
    logic [CW-1:0]    cnt_q;
    logic             c_q, x_q, g_q, carry_d;
    logic             busy_q, done_q, cout_q;
    logic [WIDTH-1:0] sum_q;

    logic ha_a, ha_b, ha_s, ha_c;

    // Input mux of the shared cell; idle states park it at 0,0.
    always_comb begin
        ha_a = 1'b0;
        ha_b = 1'b0;
        case (state_q)
            P1: begin
                ha_a = a_sh_q[0];
                ha_b = b_sh_q[0];
            end
            P2: begin
                ha_a = x_q;
                ha_b = c_q;
            end
            default: ;
        endcase
    end

    serial_add_ctrl_ha_str u_ha_str (
        .a_i     (ha_a),
        .b_i     (ha_b),
        .sum_o   (ha_s),
        .carry_o (ha_c)
    );

    generate
        if (WIDTH == 1) begin : g_sh1
            assign s_sh_d = ha_s;
        end else begin : g_shn
            assign s_sh_d = {ha_s, s_sh_q[WIDTH-1:1]};
        end
    endgenerate

    assign carry_d = g_q | ha_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            s_sh_q  <= '0;
            cnt_q   <= '0;
            c_q     <= 1'b0;
            x_q     <= 1'b0;
            g_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_sh_q  <= a;
                        b_sh_q  <= b;
                        c_q     <= cin;
                        cnt_q   <= '0;
                        state_q <= P1;
                        busy_q  <= 1'b1;
                    end
                end
                P1: begin
                    x_q     <= ha_s;
                    g_q     <= ha_c;
                    state_q <= P2;
                end
                P2: begin
                    s_sh_q <= s_sh_d;
                    c_q    <= carry_d;
                    a_sh_q <= a_sh_q >> 1;
                    b_sh_q <= b_sh_q >> 1;
                    cnt_q  <= cnt_q + CW'(1);
                    // Result registers are only touched with the complete word.
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        sum_q   <= s_sh_d;
                        cout_q  <= carry_d;
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= P1;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule
